// File: rtl/full_sub_pkg.sv
// -----------------------------------------------------------------------------
// full_sub_pkg
//
// Shared definitions for the registered one-bit full subtractor slice.
//
// Contents:
//   MINUEND_IDX / SUBTRAHEND_IDX / BORROW_IN_IDX : bit positions inside the
//                                                  3-bit operand vector a.
//   OPERAND_W                                    : width of the operand vector.
//   CNT_W_DEFAULT                                : default borrow counter width.
//   sub_result_t                                 : packed {d, b} result pair.
//   borrow_of / diff_of                          : reference helpers for the
//                                                  subtractor equations.
// -----------------------------------------------------------------------------
package full_sub_pkg;

  localparam int OPERAND_W      = 3;
  localparam int MINUEND_IDX    = 2;
  localparam int SUBTRAHEND_IDX = 1;
  localparam int BORROW_IN_IDX  = 0;
  localparam int CNT_W_DEFAULT  = 8;

  // Difference and borrow travel together through the output register.
  typedef struct packed {
    logic d;
    logic b;
  } sub_result_t;

  // Difference bit of x - y - bin.
  function automatic logic diff_of(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Borrow-out of x - y - bin: borrow when y exceeds x outright, or when
  // x and y are equal and a borrow arrives from the lower slice.
  function automatic logic borrow_of(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage : full_sub_pkg

// File: rtl/full_sub_if.sv
// -----------------------------------------------------------------------------
// full_sub_if
//
// Operand / result bundle of the full subtractor slice.
//
// Signals:
//   a         [2:0] operand vector {minuend x, subtrahend y, borrow-in bin}
//   a_valid         a carries a valid operand this cycle
//   d               registered difference
//   b               registered borrow-out
//   out_valid       d/b hold a fresh result
//
// Modports:
//   master : the producer of operands / consumer of results (parent or bench)
//   slave  : the subtractor slice itself
// -----------------------------------------------------------------------------
interface full_sub_if;
  import full_sub_pkg::*;

  logic [OPERAND_W-1:0] a;
  logic                 a_valid;
  logic                 d;
  logic                 b;
  logic                 out_valid;

  modport master (
    output a,
    output a_valid,
    input  d,
    input  b,
    input  out_valid
  );

  modport slave (
    input  a,
    input  a_valid,
    output d,
    output b,
    output out_valid
  );

endinterface : full_sub_if

// File: rtl/full_sub_core.sv
// -----------------------------------------------------------------------------
// full_sub_core
//
// Purely combinational one-bit full subtractor: computes x - y - bin.
// No state, no clock; the parent registers the result.
//
// Ports:
//   x    in  1  minuend
//   y    in  1  subtrahend
//   bin  in  1  borrow-in from the lower slice
//   d    out 1  difference
//   b    out 1  borrow-out to the upper slice
// -----------------------------------------------------------------------------
module full_sub_core
  import full_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic b
);

  // X on any input propagates naturally through these operators; the core
  // makes no attempt to filter unknowns.
  assign d = diff_of(x, y, bin);
  assign b = borrow_of(x, y, bin);

endmodule : full_sub_core

// File: rtl/full_sub.sv
// -----------------------------------------------------------------------------
// full_sub
//
// Registered one-bit full subtractor slice. Operands sampled on a rising clk
// edge with a_valid=1 produce d/b one cycle later with out_valid=1. With
// a_valid=0 the previous d/b are held and out_valid drops. One result per
// cycle, no back-pressure. Reset is asynchronous and active-high.
//
// Optional feature macro: FULL_SUB_STATUS_EN
//   When defined, adds borrow_cnt: a saturating count of valid results whose
//   borrow-out is 1, cleared only by rst.
//
// Parameters:
//   CNT_W      width of borrow_cnt (only meaningful with FULL_SUB_STATUS_EN)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   bus        slave       full_sub_if (a, a_valid, d, b, out_valid)
//   borrow_cnt out  CNT_W  saturating borrow count (FULL_SUB_STATUS_EN only)
// -----------------------------------------------------------------------------
module full_sub
  import full_sub_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  full_sub_if.slave      bus
`ifdef FULL_SUB_STATUS_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  // Reject a degenerate counter width at elaboration time.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("full_sub: CNT_W must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Combinational core
  // ---------------------------------------------------------------------------
  sub_result_t core_res;

  full_sub_core u_core (
    .x   (bus.a[MINUEND_IDX]),
    .y   (bus.a[SUBTRAHEND_IDX]),
    .bin (bus.a[BORROW_IN_IDX]),
    .d   (core_res.d),
    .b   (core_res.b)
  );

  // ---------------------------------------------------------------------------
  // Result register and valid tracking
  // ---------------------------------------------------------------------------
  sub_result_t res_reg;
  logic        out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      // out_valid is a one-cycle flag per accepted operand, while d/b keep
      // the last accepted result across idle cycles.
      out_valid_reg <= bus.a_valid;
      if (bus.a_valid) begin
        res_reg <= core_res;
      end
    end
  end

  assign bus.d         = res_reg.d;
  assign bus.b         = res_reg.b;
  assign bus.out_valid = out_valid_reg;

  // ---------------------------------------------------------------------------
  // Optional saturating borrow counter
  // ---------------------------------------------------------------------------
`ifdef FULL_SUB_STATUS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] borrow_cnt_reg;
  logic [CNT_W-1:0] borrow_cnt_next;

  // Counts on the core borrow at the sampling edge, so the count moves in
  // the same cycle that the corresponding result appears on b.
  always_comb begin
    borrow_cnt_next = borrow_cnt_reg;
    if (bus.a_valid && core_res.b && (borrow_cnt_reg != CNT_MAX)) begin
      borrow_cnt_next = borrow_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      borrow_cnt_reg <= '0;
    end else begin
      borrow_cnt_reg <= borrow_cnt_next;
    end
  end

  assign borrow_cnt = borrow_cnt_reg;
`endif

endmodule : full_sub

// File: tb/tb_full_sub.sv
// -----------------------------------------------------------------------------
// tb_full_sub
//
// Directed self-checking bench for full_sub. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// loaded them. Counter checks are compiled in with FULL_SUB_STATUS_EN.
// -----------------------------------------------------------------------------
module tb_full_sub;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;

  full_sub_if bus_if ();

`ifdef FULL_SUB_STATUS_EN
  logic [CNT_W-1:0] borrow_cnt;
`endif

  full_sub #(
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if)
`ifdef FULL_SUB_STATUS_EN
    ,
    .borrow_cnt (borrow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed truth table, bit i = result for a == i.
  // d: 000->0 001->1 010->1 011->0 100->1 101->0 110->0 111->1
  // b: 000->0 001->1 010->1 011->1 100->0 101->0 110->0 111->1
  logic [7:0] d_tbl = 8'b1001_0110;
  logic [7:0] b_tbl = 8'b1000_1110;

  task automatic check_out(input string name, input logic exp_d,
                           input logic exp_b, input logic exp_v);
    n_checks++;
    if (bus_if.d !== exp_d || bus_if.b !== exp_b || bus_if.out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got d=%b b=%b out_valid=%b, expected d=%b b=%b out_valid=%b",
               name, bus_if.d, bus_if.b, bus_if.out_valid, exp_d, exp_b, exp_v);
    end else begin
      $display("ok   %s: d=%b b=%b out_valid=%b", name, bus_if.d, bus_if.b, bus_if.out_valid);
    end
  endtask

  task automatic test_reset();
    // Load a non-zero result first so the asynchronous clear is visible.
    @(negedge clk);
    rst = 1'b0;
    bus_if.a = 3'b111; bus_if.a_valid = 1'b1;
    @(negedge clk);
    check_out("reset_preload", 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;          // mid-cycle, no clock edge yet
    #1 check_out("reset_async", 1'b0, 1'b0, 1'b0);
`ifdef FULL_SUB_STATUS_EN
    n_checks++;
    if (borrow_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d expected 0", borrow_cnt);
    end
`endif
    // a=111 valid held during reset over several edges must be ignored.
    repeat (3) @(negedge clk);
    check_out("reset_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus_if.a_valid = 1'b0;
    @(negedge clk);
    check_out("reset_release_idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    logic [2:0] av;
    for (int i = 0; i < 8; i++) begin
      av = 3'(i);
      bus_if.a = av; bus_if.a_valid = 1'b1;
      @(negedge clk);
      check_out($sformatf("sweep_a%03b", av), d_tbl[i], b_tbl[i], 1'b1);
    end
    bus_if.a_valid = 1'b0;
    @(negedge clk);
    check_out("sweep_tail_hold", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    bus_if.a = 3'b001; bus_if.a_valid = 1'b1;
    @(negedge clk);
    check_out("hold_load_001", 1'b1, 1'b1, 1'b1);
    bus_if.a = 3'b110; bus_if.a_valid = 1'b0;
    @(negedge clk);
    check_out("hold_invalid_110", 1'b1, 1'b1, 1'b0);
    // A valid 100 afterwards must load (d=1, b=0).
    bus_if.a = 3'b100; bus_if.a_valid = 1'b1;
    @(negedge clk);
    check_out("hold_then_100", 1'b1, 1'b0, 1'b1);
    bus_if.a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_midrun_reset();
    bus_if.a = 3'b010; bus_if.a_valid = 1'b1;
    @(negedge clk);
    check_out("midrun_load_010", 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 check_out("midrun_async_clear", 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    bus_if.a = 3'b101; bus_if.a_valid = 1'b1;
    @(negedge clk);
    check_out("midrun_next_101", 1'b0, 1'b0, 1'b1);
    bus_if.a_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef FULL_SUB_STATUS_EN
  task automatic test_counter();
    logic [CNT_W-1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_if.a = 3'b001; bus_if.a_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (borrow_cnt !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL counter_step%0d: got %0d expected %0d", i, borrow_cnt, exp_seq[i]);
      end else begin
        $display("ok   counter_step%0d: borrow_cnt=%0d", i, borrow_cnt);
      end
    end
    bus_if.a = 3'b100; bus_if.a_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (borrow_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL counter_no_borrow: got %0d expected 3", borrow_cnt);
    end else begin
      $display("ok   counter_no_borrow: borrow_cnt=%0d", borrow_cnt);
    end
    bus_if.a_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus_if.a = 3'b000;
    bus_if.a_valid = 1'b0;
    test_reset();
    test_sweep();
    test_hold();
    test_midrun_reset();
`ifdef FULL_SUB_STATUS_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_sub
